// File: rtl/noc_pkg.sv
// Shared definitions for the NOC command decoder: opcode encoding, opcode field
// position and the decoder state type.
package noc_pkg;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 5;

   typedef enum logic [2:0] {
      OPC_NOP   = 3'b000,
      OPC_WRITE = 3'b001,
      OPC_READ  = 3'b010
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_ADDR,
      ST_W_LEN,
      ST_W_DATA,
      ST_R_ADDR,
      ST_R_LEN
   } dec_state_e;

   function automatic logic [2:0] get_opcode(input logic [7:0] cmd_byte);
      return cmd_byte[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/noc_cmd_decoder_if.sv
// Bundle of the decoder's NOC input stream, state-buffer write port, read
// request handshake and status outputs.
interface noc_cmd_decoder_if #(parameter int ADDR_W = 8);

   logic              noc_to_dev_ctl;
   logic [7:0]        noc_to_dev_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_len;
   logic              rd_ack;
   logic              busy;
   logic              err;

   modport master (
      output noc_to_dev_ctl, noc_to_dev_data, rd_ack,
      input  wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_len, busy, err
   );

   modport slave (
      input  noc_to_dev_ctl, noc_to_dev_data, rd_ack,
      output wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_len, busy, err
   );

endinterface

// File: rtl/noc_cmd_decoder.sv
// Decodes the raw NOC byte stream into state-buffer byte writes and read
// requests; one byte is consumed every cycle, no backpressure.
module noc_cmd_decoder
   import noc_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input logic              clk,
   input logic              reset,
   noc_cmd_decoder_if.slave bus
);

   dec_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic              drop_q, drop_d;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              rd_req_q, rd_req_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]        rd_len_q, rd_len_d;
   logic              err_q, err_d;

   logic [2:0]        opc;
   logic [ADDR_W-1:0] byte_addr;

   assign opc       = get_opcode(bus.noc_to_dev_data);
   assign byte_addr = ADDR_W'(bus.noc_to_dev_data);

   // A command byte always wins: it aborts any frame in flight and is decoded
   // as a fresh command in the same cycle.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      drop_d    = drop_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_req_d  = rd_req_q;
      rd_addr_d = rd_addr_q;
      rd_len_d  = rd_len_q;
      err_d     = 1'b0;

      if (rd_req_q && bus.rd_ack) begin
         rd_req_d = 1'b0;
      end

      if (bus.noc_to_dev_ctl) begin
         if (state_q != ST_IDLE) begin
            err_d = 1'b1;
         end
         case (opc)
            OPC_NOP: begin
               state_d = ST_IDLE;
            end
            OPC_WRITE: begin
               state_d = ST_W_ADDR;
            end
            OPC_READ: begin
               state_d = ST_R_ADDR;
               drop_d  = rd_req_q && !bus.rd_ack;
               if (rd_req_q && !bus.rd_ack) begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         endcase
      end else begin
         case (state_q)
            ST_W_ADDR: begin
               addr_d  = byte_addr;
               state_d = ST_W_LEN;
            end
            ST_W_LEN: begin
               len_d   = bus.noc_to_dev_data;
               state_d = (bus.noc_to_dev_data == 8'd0) ? ST_IDLE : ST_W_DATA;
            end
            ST_W_DATA: begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = bus.noc_to_dev_data;
               addr_d    = addr_q + 1'b1;
               len_d     = len_q - 8'd1;
               if (len_q == 8'd1) begin
                  state_d = ST_IDLE;
               end
            end
            ST_R_ADDR: begin
               addr_d  = byte_addr;
               state_d = ST_R_LEN;
            end
            ST_R_LEN: begin
               len_d   = bus.noc_to_dev_data;
               state_d = ST_IDLE;
               // A READ that collided with a pending request is parsed but never issued.
               if (!drop_q) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = addr_q;
                  rd_len_d  = bus.noc_to_dev_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         drop_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
         rd_len_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         drop_q    <= drop_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_req_q  <= rd_req_d;
         rd_addr_q <= rd_addr_d;
         rd_len_q  <= rd_len_d;
         err_q     <= err_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.rd_req  = rd_req_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.rd_len  = rd_len_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noc_cmd_decoder.sv
// Bench for noc_cmd_decoder: directed vector table, a reset-mid-frame sequence
// and a randomized frame stream checked against a frame-level reference model.
module tb_noc_cmd_decoder;

   logic clk;
   logic reset;

   noc_cmd_decoder_if #(.ADDR_W(8)) bus ();

   noc_cmd_decoder #(.ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       ctl;
      logic [7:0] data;
      logic       ack;
      logic       wr_en;
      logic [7:0] wa;
      logic [7:0] wd;
      logic       rq;
      logic [7:0] ra;
      logic [7:0] rl;
      logic       busy;
      logic       err;
   } vec_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } pair_t;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t  vecs[$];
   pair_t exp_wr[$], obs_wr[$], exp_rd[$], obs_rd[$];
   logic  stim_ctl[$];
   logic [7:0] stim_data[$];
   int    exp_err = 0;
   int    obs_err = 0;
   bit    mon_on  = 1'b0;

   function automatic vec_t mk(input logic rst, ctl, input logic [7:0] data, input logic ack,
                               input logic wr_en, input logic [7:0] wa, wd,
                               input logic rq, input logic [7:0] ra, rl,
                               input logic busy, err);
      vec_t v;
      v.rst = rst; v.ctl = ctl; v.data = data; v.ack = ack;
      v.wr_en = wr_en; v.wa = wa; v.wd = wd;
      v.rq = rq; v.ra = ra; v.rl = rl; v.busy = busy; v.err = err;
      return v;
   endfunction

   // Inputs change 1 time unit after a rising edge and are sampled on the next one.
   task automatic apply_stimulus(input logic rst, ctl, input logic [7:0] data, input logic ack);
      reset               = rst;
      bus.noc_to_dev_ctl  = ctl;
      bus.noc_to_dev_data = data;
      bus.rd_ack          = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Don't-care address/data fields are masked when their strobe is expected low.
   task automatic check_vec(input string name, input vec_t v);
      logic [63:0] act, exp;
      act = {28'd0, bus.wr_en, v.wr_en ? bus.wr_addr : 8'd0, v.wr_en ? bus.wr_data : 8'd0,
             bus.rd_req, v.rq ? bus.rd_addr : 8'd0, v.rq ? bus.rd_len : 8'd0, bus.busy, bus.err};
      exp = {28'd0, v.wr_en, v.wr_en ? v.wa : 8'd0, v.wr_en ? v.wd : 8'd0,
             v.rq, v.rq ? v.ra : 8'd0, v.rq ? v.rl : 8'd0, v.busy, v.err};
      check_output(name, act, exp);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (bus.wr_en) obs_wr.push_back('{a: bus.wr_addr, d: bus.wr_data});
         if (bus.rd_req) obs_rd.push_back('{a: bus.rd_addr, d: bus.rd_len});
         if (bus.err) obs_err++;
      end
   end

   task automatic build_table();
      //            rst ctl data  ack  we wa     wd     rq ra     rl     bsy err
      vecs.push_back(mk(1, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // basic write
      vecs.push_back(mk(0, 1, 8'h20, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h10, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h03, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'hAA, 0,  1, 8'h10, 8'hAA, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'hBB, 0,  1, 8'h11, 8'hBB, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'hCC, 0,  1, 8'h12, 8'hCC, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h5A, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // address wrap
      vecs.push_back(mk(0, 1, 8'h20, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'hFE, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h03, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h01, 0,  1, 8'hFE, 8'h01, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h02, 0,  1, 8'hFF, 8'h02, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h03, 0,  1, 8'h00, 8'h03, 0, 8'h00, 8'h00, 0, 0));
      // illegal opcodes back to back
      vecs.push_back(mk(0, 1, 8'hE0, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1));
      vecs.push_back(mk(0, 1, 8'hA0, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // write of length zero
      vecs.push_back(mk(0, 1, 8'h20, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h40, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h55, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // write aborted by a read command
      vecs.push_back(mk(0, 1, 8'h20, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h30, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h04, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h11, 0,  1, 8'h30, 8'h11, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h22, 0,  1, 8'h31, 8'h22, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 1, 8'h40, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 1));
      vecs.push_back(mk(0, 0, 8'h07, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h02, 0,  0, 8'h00, 8'h00, 1, 8'h07, 8'h02, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // read held across a slow acknowledge
      vecs.push_back(mk(0, 1, 8'h40, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h05, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h08, 0,  0, 8'h00, 8'h00, 1, 8'h05, 8'h08, 0, 0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h05, 8'h08, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // second read while the first is unacknowledged
      vecs.push_back(mk(0, 1, 8'h40, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h05, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h08, 0,  0, 8'h00, 8'h00, 1, 8'h05, 8'h08, 0, 0));
      vecs.push_back(mk(0, 1, 8'h40, 0,  0, 8'h00, 8'h00, 1, 8'h05, 8'h08, 1, 1));
      vecs.push_back(mk(0, 0, 8'h66, 0,  0, 8'h00, 8'h00, 1, 8'h05, 8'h08, 1, 0));
      vecs.push_back(mk(0, 0, 8'h09, 0,  0, 8'h00, 8'h00, 1, 8'h05, 8'h08, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
      // NOP aborts a write frame (write opcode with nonzero low bits)
      vecs.push_back(mk(0, 1, 8'h3F, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 0, 8'h10, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0));
   endtask

   task automatic gen_random();
      bit prev_incomplete = 1'b0;
      for (int f = 0; f < 60; f++) begin
         logic       fctl[$];
         logic [7:0] fdat[$];
         int t, keep, full, kind;
         logic [7:0] addr, len;
         t = $urandom_range(0, 99);
         addr = 8'($urandom_range(0, 255));
         kind = (t < 45) ? 1 : (t < 70) ? 2 : (t < 85) ? 0 : 3;
         case (kind)
            1: begin
               len = 8'($urandom_range(0, 6));
               fctl.push_back(1'b1); fdat.push_back({3'b001, 5'($urandom_range(0, 31))});
               fctl.push_back(1'b0); fdat.push_back(addr);
               fctl.push_back(1'b0); fdat.push_back(len);
               for (int i = 0; i < int'(len); i++) begin
                  fctl.push_back(1'b0); fdat.push_back(8'($urandom_range(0, 255)));
               end
            end
            2: begin
               len = 8'($urandom_range(0, 255));
               fctl.push_back(1'b1); fdat.push_back({3'b010, 5'($urandom_range(0, 31))});
               fctl.push_back(1'b0); fdat.push_back(addr);
               fctl.push_back(1'b0); fdat.push_back(len);
            end
            0: begin
               fctl.push_back(1'b1); fdat.push_back({3'b000, 5'($urandom_range(0, 31))});
            end
            default: begin
               fctl.push_back(1'b1);
               fdat.push_back({3'($urandom_range(3, 7)), 5'($urandom_range(0, 31))});
            end
         endcase
         full = fctl.size();
         keep = full;
         if (full > 1 && $urandom_range(0, 99) < 15) keep = $urandom_range(1, full - 1);
         if (prev_incomplete || kind == 3) exp_err++;
         if (kind == 1)
            for (int i = 3; i < keep; i++)
               exp_wr.push_back('{a: 8'(int'(fdat[1]) + i - 3), d: fdat[i]});
         if (kind == 2 && keep == 3) exp_rd.push_back('{a: fdat[1], d: fdat[2]});
         prev_incomplete = (keep < full);
         for (int i = 0; i < keep; i++) begin
            stim_ctl.push_back(fctl[i]); stim_data.push_back(fdat[i]);
         end
         if (!prev_incomplete)
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
               stim_ctl.push_back(1'b0); stim_data.push_back(8'($urandom_range(0, 255)));
            end
      end
      stim_ctl.push_back(1'b1); stim_data.push_back(8'h00);
      if (prev_incomplete) exp_err++;
   endtask

   initial begin
      reset = 1'b1;
      bus.noc_to_dev_ctl = 1'b0;
      bus.noc_to_dev_data = 8'h00;
      bus.rd_ack = 1'b0;

      build_table();
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].rst, vecs[i].ctl, vecs[i].data, vecs[i].ack);
         check_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // reset in the middle of a write payload with a read request pending
      apply_stimulus(0, 1, 8'h40, 0);
      apply_stimulus(0, 0, 8'h12, 0);
      apply_stimulus(0, 0, 8'h34, 0);
      apply_stimulus(0, 1, 8'h20, 0);
      apply_stimulus(0, 0, 8'h80, 0);
      apply_stimulus(0, 0, 8'h05, 0);
      apply_stimulus(0, 0, 8'h01, 0);
      check_output("pre_reset_write",
                   {46'd0, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_req, bus.busy},
                   {46'd0, 1'b1, 8'h80, 8'h01, 1'b1, 1'b1});
      apply_stimulus(1, 0, 8'h02, 0);
      check_output("mid_frame_reset",
                   {28'd0, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_req, bus.rd_addr,
                    bus.rd_len, bus.busy, bus.err}, 64'd0);
      apply_stimulus(0, 0, 8'h99, 0);
      check_output("post_reset_idle", {62'd0, bus.wr_en, bus.busy}, 64'd0);
      apply_stimulus(0, 1, 8'h20, 0);
      apply_stimulus(0, 0, 8'h90, 0);
      apply_stimulus(0, 0, 8'h01, 0);
      apply_stimulus(0, 0, 8'h77, 0);
      check_output("post_reset_frame",
                   {44'd0, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.err},
                   {44'd0, 1'b1, 8'h90, 8'h77, 1'b0, 1'b0});

      // randomized frame stream, requests acknowledged immediately
      apply_stimulus(1, 0, 8'h00, 1);
      gen_random();
      mon_on = 1'b1;
      foreach (stim_ctl[i]) apply_stimulus(0, stim_ctl[i], stim_data[i], 1);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 8'h00, 1);
      mon_on = 1'b0;

      check_output("rand_wr_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         check_output($sformatf("rand_wr%0d", i), {48'd0, obs_wr[i].a, obs_wr[i].d},
                      {48'd0, exp_wr[i].a, exp_wr[i].d});
      check_output("rand_rd_count", 64'(obs_rd.size()), 64'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
         check_output($sformatf("rand_rd%0d", i), {48'd0, obs_rd[i].a, obs_rd[i].d},
                      {48'd0, exp_rd[i].a, exp_rd[i].d});
      check_output("rand_err_count", 64'(obs_err), 64'(exp_err));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
